contador_modular: RTL and testbench

- Parametrised successor of the team's free-running 4-bit event counter.
- Adds configurable width and modulo, up/down direction, parallel load, synchronous clear, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used wherever the design counts events, such as scores, attempts or timeouts, against a programmable limit.

---
 rtl/contador_modular.sv | 83 ++++++++
 tb/tb_contador_modular.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_modular.sv
// Parametrised up/down event counter with programmable modulo, parallel load,
// synchronous clear, wrap or saturate behaviour at the limits, a terminal-count
// pulse and a sticky overflow flag. All outputs are registered.
module contador_modular #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter bit          SATURATE = 1'b0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             enable_i,
    input  logic             up_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             ovf_clr_i,
    output logic [WIDTH-1:0] data_o,
    output logic             tc_o,
    output logic             ovf_o
);

    // Largest value representable in WIDTH bits, computed in 64 bits so WIDTH=32 is safe.
    localparam longint unsigned LIMIT = (64'd1 << WIDTH) - 64'd1;

    // Reject unusable configurations at elaboration time.
    if (WIDTH == 0 || WIDTH > 32 || MAX_VAL == 0 || 64'(MAX_VAL) > LIMIT) begin : gen_bad_param
        $error("contador_modular: illegal WIDTH=%0d / MAX_VAL=%0d", WIDTH, MAX_VAL);
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] next_count;
    logic             tc;
    logic             ovf;
    logic             boundary;

    // Next count and boundary detection; clear > load > enable. Compare-then-select
    // keeps every intermediate inside WIDTH bits and never relies on modular overflow.
    always_comb begin
        next_count = count;
        boundary   = 1'b0;
        if (clear_i) begin
            next_count = '0;
        end else if (load_i) begin
            next_count = (load_val_i > MAX) ? MAX : load_val_i;
        end else if (enable_i) begin
            if (up_i) begin
                if (count >= MAX) begin
                    boundary   = 1'b1;
                    next_count = SATURATE ? MAX : '0;
                end else begin
                    next_count = count + WIDTH'(1);
                end
            end else begin
                if (count == '0) begin
                    boundary   = 1'b1;
                    next_count = SATURATE ? '0 : MAX;
                end else begin
                    next_count = count - WIDTH'(1);
                end
            end
        end
    end

    // State update; reset overrides everything, a boundary event beats ovf_clr_i.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count <= '0;
            tc    <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            tc    <= boundary;
            ovf   <= boundary | (ovf & ~ovf_clr_i);
        end
    end

    assign data_o = count;
    assign tc_o   = tc;
    assign ovf_o  = ovf;

endmodule

// File: tb/tb_contador_modular.sv
// Bench for contador_modular: three instances (4-bit/9 wrap, 4-bit/9 saturate,
// 1-bit/1 wrap) share one directed stimulus; an arithmetic model is checked every
// cycle and hand-computed literals pin the model along the directed scenarios.
module tb_contador_modular;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       up = 1'b0;
    logic       clr = 1'b0;
    logic       ld = 1'b0;
    logic [3:0] lv = 4'd0;
    logic       oc = 1'b0;

    logic [3:0] d_a, d_b;
    logic [0:0] d_c;
    logic       tc_a, tc_b, tc_c;
    logic       ov_a, ov_b, ov_c;
    logic [0:0] lv_c;

    assign lv_c = lv[0:0];

    always #5 clk = ~clk;

    contador_modular #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) dut_a (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv), .ovf_clr_i(oc), .data_o(d_a), .tc_o(tc_a), .ovf_o(ov_a)
    );

    contador_modular #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b1)) dut_b (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv), .ovf_clr_i(oc), .data_o(d_b), .tc_o(tc_b), .ovf_o(ov_b)
    );

    contador_modular #(.WIDTH(1), .MAX_VAL(1), .SATURATE(1'b0)) dut_c (
        .clk_i(clk), .rst_i(rst), .enable_i(en), .up_i(up), .clear_i(clr), .load_i(ld),
        .load_val_i(lv_c), .ovf_clr_i(oc), .data_o(d_c), .tc_o(tc_c), .ovf_o(ov_c)
    );

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic with a modulo for wrapping.
    int maxv [3] = '{9, 9, 1};
    bit satv [3] = '{1'b0, 1'b1, 1'b0};
    int m_cnt [3] = '{0, 0, 0};
    int m_tc [3] = '{0, 0, 0};
    int m_ovf [3] = '{0, 0, 0};

    always @(posedge clk) begin
        int val, nxt, hit;
        for (int k = 0; k < 3; k++) begin
            val = (k == 2) ? (int'(lv) % 2) : int'(lv);
            if (rst) begin
                m_cnt[k] = 0;
                m_tc[k]  = 0;
                m_ovf[k] = 0;
            end else begin
                hit = 0;
                if (clr) begin
                    m_cnt[k] = 0;
                end else if (ld) begin
                    m_cnt[k] = (val > maxv[k]) ? maxv[k] : val;
                end else if (en) begin
                    nxt = up ? m_cnt[k] + 1 : m_cnt[k] - 1;
                    if (nxt > maxv[k] || nxt < 0) begin
                        hit = 1;
                        if (!satv[k]) m_cnt[k] = (nxt + maxv[k] + 1) % (maxv[k] + 1);
                    end else begin
                        m_cnt[k] = nxt;
                    end
                end
                m_tc[k]  = hit;
                m_ovf[k] = (hit != 0 || (m_ovf[k] != 0 && !oc)) ? 1 : 0;
            end
        end
    end

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (check_en) begin
            chk("a_data", int'(d_a), m_cnt[0]);
            chk("a_tc", int'(tc_a), m_tc[0]);
            chk("a_ovf", int'(ov_a), m_ovf[0]);
            chk("b_data", int'(d_b), m_cnt[1]);
            chk("b_tc", int'(tc_b), m_tc[1]);
            chk("b_ovf", int'(ov_b), m_ovf[1]);
            chk("c_data", int'(d_c), m_cnt[2]);
            chk("c_tc", int'(tc_c), m_tc[2]);
            chk("c_ovf", int'(ov_c), m_ovf[2]);
        end
    end

    task automatic drive(input bit r, input bit e, input bit u, input bit c, input bit l,
                         input int v, input bit o);
        rst = r; en = e; up = u; clr = c; ld = l; lv = 4'(v); oc = o;
    endtask

    // One rising edge, then return at the following falling edge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    int exp1 [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};

    initial begin
        @(negedge clk);
        // Reset state
        drive(1, 0, 0, 0, 0, 0, 0);
        tick();
        check_en = 1'b1;
        chk("rst_a_data", int'(d_a), 0);
        chk("rst_a_tc", int'(tc_a), 0);
        chk("rst_a_ovf", int'(ov_a), 0);

        // Wrap-mode up count through MAX_VAL
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            tick();
            chk("t1_data", int'(d_a), exp1[i]);
            chk("t1_tc", int'(tc_a), (i == 9) ? 1 : 0);
            chk("t1_ovf", int'(ov_a), (i >= 9) ? 1 : 0);
        end

        // Saturate-mode: load 8 then three up-steps
        drive(0, 0, 1, 0, 1, 8, 0);
        tick();
        chk("t2_load", int'(d_b), 8);
        drive(0, 1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t2_data", int'(d_b), 9);
            chk("t2_tc", int'(tc_b), (i > 0) ? 1 : 0);
        end

        // Down-count from 1: wrap instance 0,9,8; saturate instance 0,0,0
        drive(0, 0, 0, 0, 1, 1, 0);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0);
        tick();
        chk("t3_a0", int'(d_a), 0);
        chk("t3_b0", int'(d_b), 0);
        tick();
        chk("t3_a1", int'(d_a), 9);
        chk("t3_a1_tc", int'(tc_a), 1);
        chk("t3_b1", int'(d_b), 0);
        chk("t3_b1_tc", int'(tc_b), 1);
        tick();
        chk("t3_a2", int'(d_a), 8);
        chk("t3_a2_tc", int'(tc_a), 0);
        chk("t3_b2", int'(d_b), 0);

        // Clamped load beats enable; clear beats load
        drive(0, 1, 1, 0, 1, 13, 0);
        tick();
        chk("t4_clamp", int'(d_a), 9);
        chk("t4_tc", int'(tc_a), 0);
        chk("t4_ovf", int'(ov_a), 1);
        drive(0, 0, 1, 1, 1, 5, 0);
        tick();
        chk("t4_clear", int'(d_a), 0);
        chk("t4_clear_ovf", int'(ov_a), 1);

        // ovf clear loses to a simultaneous wrap, then clears alone
        drive(0, 0, 1, 0, 1, 9, 0);
        tick();
        drive(0, 1, 1, 0, 0, 0, 1);
        tick();
        chk("t5_wrap", int'(d_a), 0);
        chk("t5_set_wins", int'(ov_a), 1);
        drive(0, 0, 1, 0, 0, 0, 1);
        tick();
        chk("t5_clr", int'(ov_a), 0);

        // Direction toggling every cycle
        drive(0, 0, 1, 0, 1, 2, 0);
        tick();
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, (i % 3) != 0, 0, 0, 0, 0);
            tick();
        end

        // Reset mid-count at 6 with enable high
        drive(0, 0, 1, 0, 1, 5, 0);
        tick();
        drive(0, 1, 1, 0, 0, 0, 0);
        tick();
        chk("t6_pre", int'(d_a), 6);
        drive(1, 1, 1, 0, 0, 0, 0);
        tick();
        chk("t6_data", int'(d_a), 0);
        chk("t6_tc", int'(tc_a), 0);
        chk("t6_ovf", int'(ov_a), 0);
        chk("t6_b_ovf", int'(ov_b), 0);

        // One-bit counter toggles 1,0,1 with tc on the 1->0 wrap
        drive(0, 1, 1, 0, 0, 0, 0);
        tick();
        chk("w1_d0", int'(d_c), 1);
        chk("w1_tc0", int'(tc_c), 0);
        tick();
        chk("w1_d1", int'(d_c), 0);
        chk("w1_tc1", int'(tc_c), 1);
        chk("w1_ovf", int'(ov_c), 1);
        tick();
        chk("w1_d2", int'(d_c), 1);
        chk("w1_tc2", int'(tc_c), 0);

        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
